hera_wb_sched: RTL and testbench

Write-back scheduler and load scoreboard for the HERA register file. The register file has a single write port. This block arbitrates that port between the ALU result, the two-word multiply result (low half to `rd`, high half to R13), and in-order memory load returns. It also tracks outstanding loads, so the decode stage can hold instructions whose sources or destination are not yet written.

---
 rtl/hera_pkg.sv | 17 +
 rtl/hera_wb_sched_if.sv | 40 ++++
 rtl/hera_wb_fifo.sv | 62 ++++++
 rtl/hera_wb_sched.sv | 198 +++++++++++++++++++
 tb/tb_hera_wb_sched.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/hera_pkg.sv
// Shared widths, register constants and the write-back entry type for the HERA
// write-back scheduler.
package hera_pkg;

   localparam int unsigned DW   = 16;
   localparam int unsigned AW   = 4;
   localparam int unsigned NREG = 1 << AW;

   localparam logic [AW-1:0] R0_ADDR  = '0;
   localparam logic [AW-1:0] R13_ADDR = AW'(13);

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/hera_wb_sched_if.sv
// Execute/decode-side bundle of the write-back scheduler: result sources, load
// traffic, hazard queries and the register-file write port.
interface hera_wb_sched_if;
   import hera_pkg::*;

   logic            alu_valid;
   logic [AW-1:0]   alu_rd;
   logic [DW-1:0]   alu_data;
   logic            mul_valid;
   logic [AW-1:0]   mul_rd;
   logic [DW-1:0]   mul_lo;
   logic [DW-1:0]   mul_hi;
   logic            ld_issue;
   logic [AW-1:0]   ld_issue_rd;
   logic            ld_ret_valid;
   logic [DW-1:0]   ld_ret_data;
   logic [AW-1:0]   rsa;
   logic [AW-1:0]   rsb;
   logic [AW-1:0]   rd_chk;
   logic            hazard;
   logic            stall;
   logic            ld_full;
   logic [NREG-1:0] busy;
   logic            wr_en;
   logic [AW-1:0]   wr_addr;
   logic [DW-1:0]   wr_data;

   modport master (
      output alu_valid, alu_rd, alu_data, mul_valid, mul_rd, mul_lo, mul_hi,
             ld_issue, ld_issue_rd, ld_ret_valid, ld_ret_data, rsa, rsb, rd_chk,
      input  hazard, stall, ld_full, busy, wr_en, wr_addr, wr_data
   );

   modport slave (
      input  alu_valid, alu_rd, alu_data, mul_valid, mul_rd, mul_lo, mul_hi,
             ld_issue, ld_issue_rd, ld_ret_valid, ld_ret_data, rsa, rsb, rd_chk,
      output hazard, stall, ld_full, busy, wr_en, wr_addr, wr_data
   );

endinterface

// File: rtl/hera_wb_fifo.sv
// Synchronous write-back FIFO: up to two pushes and one pop per cycle, with
// per-slot valid/address taps for the decode hazard compare.
module hera_wb_fifo
   import hera_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      push0,
   input  wb_entry_t                 push0_entry,
   input  logic                      push1,
   input  wb_entry_t                 push1_entry,
   input  logic                      pop,
   output wb_entry_t                 head,
   output logic [$clog2(DEPTH):0]    count,
   output logic [DEPTH-1:0]          tap_valid,
   output logic [DEPTH-1:0][AW-1:0]  tap_addr
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   wb_entry_t     mem [DEPTH];
   logic [PW-1:0] rd_ptr_q;
   logic [PW-1:0] wr_ptr_q;
   logic [CW-1:0] cnt_q;
   logic [PW-1:0] wr_ptr1;
   logic          pop_ok;

   assign pop_ok  = pop && (cnt_q != '0);
   // Second push lands right after the first, or in the first slot if alone.
   assign wr_ptr1 = wr_ptr_q + PW'(push0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_q + PW'(push0) + PW'(push1);
         rd_ptr_q <= rd_ptr_q + PW'(pop_ok);
         cnt_q    <= cnt_q + CW'(push0) + CW'(push1) - CW'(pop_ok);
      end
   end

   always_ff @(posedge clk) begin
      if (push0) mem[wr_ptr_q] <= push0_entry;
      if (push1) mem[wr_ptr1]  <= push1_entry;
   end

   assign head  = mem[rd_ptr_q];
   assign count = cnt_q;

   for (genvar i = 0; i < DEPTH; i++) begin : g_tap
      logic [PW-1:0] off;
      assign off          = PW'(i) - rd_ptr_q;
      assign tap_valid[i] = {1'b0, off} < cnt_q;
      assign tap_addr[i]  = mem[i].addr;
   end

endmodule

// File: rtl/hera_wb_sched.sv
// Register-file write-port scheduler: load return > queued write > new ALU/MUL
// result, plus an in-order load scoreboard feeding the decode hazard check.
module hera_wb_sched
   import hera_pkg::*;
#(
   parameter int unsigned WBQ_DEPTH = 4,
   parameter int unsigned LDQ_DEPTH = 2
) (
   input  logic           clk,
   input  logic           rst,
   hera_wb_sched_if.slave bus
);

   localparam int unsigned FCW = $clog2(WBQ_DEPTH) + 1;
   localparam int unsigned LPW = (LDQ_DEPTH > 1) ? $clog2(LDQ_DEPTH) : 1;
   localparam int unsigned LCW = $clog2(LDQ_DEPTH) + 1;

   // Load queue
   logic [AW-1:0]        ldq_rd_q [LDQ_DEPTH];
   logic [LDQ_DEPTH-1:0] ldq_vld_q;
   logic [LPW-1:0]       ld_head_q;
   logic [LPW-1:0]       ld_tail_q;
   logic [LCW-1:0]       ldq_cnt_q;
   logic                 ld_full;
   logic                 ld_push;
   logic                 ld_pop;
   logic                 ld_wr;
   logic [AW-1:0]        ld_head_rd;
   logic [NREG-1:0]      busy_v;

   // Write-back FIFO
   logic                    fifo_push0;
   logic                    fifo_push1;
   wb_entry_t               fifo_e0;
   wb_entry_t               fifo_e1;
   logic                    fifo_pop;
   wb_entry_t               fifo_head;
   logic [FCW-1:0]          fifo_cnt;
   logic [WBQ_DEPTH-1:0]    tap_valid;
   logic [WBQ_DEPTH-1:0][AW-1:0] tap_addr;

   logic          stall;
   logic          alu_acc;
   logic          mul_acc;
   logic          direct;
   logic          hazard;
   logic [AW-1:0] chk [3];

   logic          wr_en_q,   wr_en_d;
   logic [AW-1:0] wr_addr_q, wr_addr_d;
   logic [DW-1:0] wr_data_q, wr_data_d;

   function automatic logic [LPW-1:0] ldq_next(input logic [LPW-1:0] p);
      return (p == LPW'(LDQ_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign ld_full    = (ldq_cnt_q == LCW'(LDQ_DEPTH));
   assign ld_push    = bus.ld_issue && !ld_full;
   assign ld_pop     = bus.ld_ret_valid && (ldq_cnt_q != '0);
   assign ld_head_rd = ldq_rd_q[ld_head_q];
   // A load into R0 keeps its slot for ordering but never claims the port.
   assign ld_wr      = ld_pop && (ld_head_rd != R0_ADDR);

   assign stall    = fifo_cnt > FCW'(WBQ_DEPTH - 2);
   assign alu_acc  = bus.alu_valid && !stall;
   assign mul_acc  = bus.mul_valid && !stall;
   assign fifo_pop = !ld_wr && (fifo_cnt != '0);
   assign direct   = !ld_wr && (fifo_cnt == '0);

   always_comb begin
      busy_v = '0;
      for (int i = 0; i < int'(LDQ_DEPTH); i++) begin
         if (ldq_vld_q[i] && (ldq_rd_q[i] != R0_ADDR)) busy_v[ldq_rd_q[i]] = 1'b1;
      end
   end

   always_comb begin
      fifo_push0 = 1'b0;
      fifo_push1 = 1'b0;
      fifo_e0    = '0;
      fifo_e1    = '0;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      if (ld_wr) begin
         wr_en_d   = 1'b1;
         wr_addr_d = ld_head_rd;
         wr_data_d = bus.ld_ret_data;
      end else if (fifo_pop) begin
         wr_en_d   = 1'b1;
         wr_addr_d = fifo_head.addr;
         wr_data_d = fifo_head.data;
      end
      if (alu_acc) begin
         if (bus.alu_rd != R0_ADDR) begin
            if (direct) begin
               wr_en_d   = 1'b1;
               wr_addr_d = bus.alu_rd;
               wr_data_d = bus.alu_data;
            end else begin
               fifo_push0 = 1'b1;
               fifo_e0    = '{addr: bus.alu_rd, data: bus.alu_data};
            end
         end
      end else if (mul_acc) begin
         if (bus.mul_rd != R0_ADDR) begin
            if (direct) begin
               wr_en_d   = 1'b1;
               wr_addr_d = bus.mul_rd;
               wr_data_d = bus.mul_lo;
            end else begin
               fifo_push0 = 1'b1;
               fifo_e0    = '{addr: bus.mul_rd, data: bus.mul_lo};
            end
         end
         // High half always queues, behind the low half when that queued too.
         if (fifo_push0) begin
            fifo_push1 = 1'b1;
            fifo_e1    = '{addr: R13_ADDR, data: bus.mul_hi};
         end else begin
            fifo_push0 = 1'b1;
            fifo_e0    = '{addr: R13_ADDR, data: bus.mul_hi};
         end
      end
   end

   hera_wb_fifo #(
      .DEPTH (WBQ_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push0       (fifo_push0),
      .push0_entry (fifo_e0),
      .push1       (fifo_push1),
      .push1_entry (fifo_e1),
      .pop         (fifo_pop),
      .head        (fifo_head),
      .count       (fifo_cnt),
      .tap_valid   (tap_valid),
      .tap_addr    (tap_addr)
   );

   assign chk[0] = bus.rsa;
   assign chk[1] = bus.rsb;
   assign chk[2] = bus.rd_chk;

   // Pending = outstanding load, queued write, or a write accepted this cycle.
   always_comb begin
      hazard = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (chk[k] != R0_ADDR) begin
            if (busy_v[chk[k]]) hazard = 1'b1;
            if (ld_push && (bus.ld_issue_rd == chk[k])) hazard = 1'b1;
            if (alu_acc && (bus.alu_rd == chk[k])) hazard = 1'b1;
            if (mul_acc && ((bus.mul_rd == chk[k]) || (chk[k] == R13_ADDR))) hazard = 1'b1;
            for (int i = 0; i < int'(WBQ_DEPTH); i++) begin
               if (tap_valid[i] && (tap_addr[i] == chk[k])) hazard = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         ld_head_q <= '0;
         ld_tail_q <= '0;
         ldq_cnt_q <= '0;
         ldq_vld_q <= '0;
         for (int i = 0; i < int'(LDQ_DEPTH); i++) ldq_rd_q[i] <= '0;
      end else begin
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         if (ld_push) begin
            ldq_rd_q[ld_tail_q]  <= bus.ld_issue_rd;
            ldq_vld_q[ld_tail_q] <= 1'b1;
            ld_tail_q            <= ldq_next(ld_tail_q);
         end
         if (ld_pop) begin
            ldq_vld_q[ld_head_q] <= 1'b0;
            ld_head_q            <= ldq_next(ld_head_q);
         end
         ldq_cnt_q <= ldq_cnt_q + LCW'(ld_push) - LCW'(ld_pop);
      end
   end

   assign bus.hazard  = hazard;
   assign bus.stall   = stall;
   assign bus.ld_full = ld_full;
   assign bus.busy    = busy_v;
   assign bus.wr_en   = wr_en_q;
   assign bus.wr_addr = wr_addr_q;
   assign bus.wr_data = wr_data_q;

endmodule

// File: tb/tb_hera_wb_sched.sv
// Directed table-driven bench for hera_wb_sched: one row per cycle, plus a
// hand-written mid-operation reset sequence.
module tb_hera_wb_sched;
   import hera_pkg::*;

   typedef struct {
      logic        av;  logic [3:0] ard; logic [15:0] adat;
      logic        mv;  logic [3:0] mrd; logic [15:0] mlo; logic [15:0] mhi;
      logic        li;  logic [3:0] lrd;
      logic        lr;  logic [15:0] ldat;
      logic [3:0]  rsa; logic [3:0] rsb; logic [3:0] rdc;
      logic        e_haz; logic e_stall; logic e_full; logic [15:0] e_busy;
      logic        e_wen; logic [3:0] e_waddr; logic [15:0] e_wdata;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   total  = 0;
   int   passed = 0;

   hera_wb_sched_if bus ();

   hera_wb_sched #(
      .WBQ_DEPTH (4),
      .LDQ_DEPTH (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic vec_t nop();
      vec_t r;
      r.av = 0; r.ard = 0; r.adat = 0; r.mv = 0; r.mrd = 0; r.mlo = 0; r.mhi = 0;
      r.li = 0; r.lrd = 0; r.lr = 0; r.ldat = 0; r.rsa = 0; r.rsb = 0; r.rdc = 0;
      r.e_haz = 0; r.e_stall = 0; r.e_full = 0; r.e_busy = 0;
      r.e_wen = 0; r.e_waddr = 0; r.e_wdata = 0;
      return r;
   endfunction

   function automatic vec_t wr(input vec_t r, input logic [3:0] a, input logic [15:0] d);
      vec_t o = r;
      o.e_wen = 1; o.e_waddr = a; o.e_wdata = d;
      return o;
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, required %h", name, act, exp);
   endtask

   task automatic apply(input vec_t r);
      bus.alu_valid = r.av;  bus.alu_rd = r.ard;  bus.alu_data = r.adat;
      bus.mul_valid = r.mv;  bus.mul_rd = r.mrd;  bus.mul_lo = r.mlo; bus.mul_hi = r.mhi;
      bus.ld_issue = r.li;   bus.ld_issue_rd = r.lrd;
      bus.ld_ret_valid = r.lr; bus.ld_ret_data = r.ldat;
      bus.rsa = r.rsa; bus.rsb = r.rsb; bus.rd_chk = r.rdc;
   endtask

   task automatic check_row(input vec_t r, input string tag);
      chk({tag, " hazard"}, 16'(bus.hazard), 16'(r.e_haz));
      chk({tag, " stall"}, 16'(bus.stall), 16'(r.e_stall));
      chk({tag, " ld_full"}, 16'(bus.ld_full), 16'(r.e_full));
      chk({tag, " busy"}, bus.busy, r.e_busy);
      chk({tag, " wr_en"}, 16'(bus.wr_en), 16'(r.e_wen));
      if (r.e_wen) begin
         chk({tag, " wr_addr"}, 16'(bus.wr_addr), 16'(r.e_waddr));
         chk({tag, " wr_data"}, bus.wr_data, r.e_wdata);
      end
   endtask

   task automatic step(input vec_t r, input string tag);
      apply(r);
      @(negedge clk);
      check_row(r, tag);
      @(posedge clk);
      #1;
   endtask

   vec_t tbl[$];
   vec_t r;

   initial begin
      rst = 1'b0;
      apply(nop());
      #3;
      chk("reset wr_en", 16'(bus.wr_en), 16'h0);
      chk("reset stall", 16'(bus.stall), 16'h0);
      #9 rst = 1'b1;
      @(posedge clk);
      #1;

      // Idle after reset, then ALU rd3 and its hazard window.
      r = nop(); tbl.push_back(r);
      r = nop(); r.av = 1; r.ard = 3; r.adat = 16'h1234; r.rsa = 3; r.e_haz = 1; tbl.push_back(r);
      r = nop(); r.rsa = 3; tbl.push_back(wr(r, 3, 16'h1234));
      r = nop(); tbl.push_back(r);
      // Multiply with free port: lo direct, hi queued.
      r = nop(); r.mv = 1; r.mrd = 2; r.mlo = 16'h00FF; r.mhi = 16'hABCD; r.rsa = 13;
      r.e_haz = 1; tbl.push_back(r);
      r = nop(); r.rsa = 13; r.e_haz = 1; tbl.push_back(wr(r, 2, 16'h00FF));
      r = nop(); r.rsa = 13; tbl.push_back(wr(r, 13, 16'hABCD));
      r = nop(); tbl.push_back(r);
      // Load return collides with a multiply.
      r = nop(); r.li = 1; r.lrd = 5; r.rsb = 5; r.e_haz = 1; tbl.push_back(r);
      r = nop(); r.rsb = 5; r.e_haz = 1; r.e_busy = 16'h0020; tbl.push_back(r);
      r = nop(); r.lr = 1; r.ldat = 16'h8000; r.mv = 1; r.mrd = 4; r.mlo = 16'h0001;
      r.mhi = 16'h0002; r.rsa = 4; r.e_haz = 1; r.e_busy = 16'h0020; tbl.push_back(r);
      r = nop(); r.rdc = 4; r.e_haz = 1; tbl.push_back(wr(r, 5, 16'h8000));
      r = nop(); r.rdc = 4; tbl.push_back(wr(r, 4, 16'h0001));
      r = nop(); tbl.push_back(wr(r, 13, 16'h0002));
      r = nop(); tbl.push_back(r);
      // Back-to-back multiplies behind two load returns; held ALU write.
      r = nop(); r.li = 1; r.lrd = 5; tbl.push_back(r);
      r = nop(); r.li = 1; r.lrd = 6; r.e_busy = 16'h0020; tbl.push_back(r);
      r = nop(); r.lr = 1; r.ldat = 16'hAAAA; r.mv = 1; r.mrd = 2; r.mlo = 16'h1111;
      r.mhi = 16'h2222; r.e_busy = 16'h0060; r.e_full = 1; tbl.push_back(r);
      r = nop(); r.lr = 1; r.ldat = 16'hBBBB; r.mv = 1; r.mrd = 3; r.mlo = 16'h3333;
      r.mhi = 16'h4444; r.e_busy = 16'h0040; tbl.push_back(wr(r, 5, 16'hAAAA));
      r = nop(); r.av = 1; r.ard = 9; r.adat = 16'h9999; r.rsa = 9; r.e_stall = 1;
      tbl.push_back(wr(r, 6, 16'hBBBB));
      r = nop(); r.av = 1; r.ard = 9; r.adat = 16'h9999; r.rsb = 3; r.e_haz = 1; r.e_stall = 1;
      tbl.push_back(wr(r, 2, 16'h1111));
      r = nop(); r.av = 1; r.ard = 9; r.adat = 16'h9999; r.rsa = 9; r.e_haz = 1;
      tbl.push_back(wr(r, 13, 16'h2222));
      r = nop(); tbl.push_back(wr(r, 3, 16'h3333));
      r = nop(); tbl.push_back(wr(r, 13, 16'h4444));
      r = nop(); tbl.push_back(wr(r, 9, 16'h9999));
      r = nop(); tbl.push_back(r);
      // Scoreboard: loads to R7 and R0, dropped issue while full, R0 return.
      r = nop(); r.li = 1; r.lrd = 7; tbl.push_back(r);
      r = nop(); r.li = 1; r.lrd = 0; r.rsb = 7; r.e_haz = 1; r.e_busy = 16'h0080; tbl.push_back(r);
      r = nop(); r.rsb = 7; r.e_haz = 1; r.e_busy = 16'h0080; r.e_full = 1; tbl.push_back(r);
      r = nop(); r.lr = 1; r.ldat = 16'h7777; r.li = 1; r.lrd = 8; r.rsa = 8;
      r.e_busy = 16'h0080; r.e_full = 1; tbl.push_back(r);
      r = nop(); r.lr = 1; r.ldat = 16'h5555; r.rsa = 7; tbl.push_back(wr(r, 7, 16'h7777));
      r = nop(); r.rsa = 8; tbl.push_back(r);
      r = nop(); r.lr = 1; r.ldat = 16'h1111; tbl.push_back(r);
      r = nop(); tbl.push_back(r);
      // ALU write to R0 is discarded.
      r = nop(); r.av = 1; r.ard = 0; r.adat = 16'hFFFF; tbl.push_back(r);
      r = nop(); tbl.push_back(r);
      // R0 load return leaves the port to a same-cycle multiply.
      r = nop(); r.li = 1; r.lrd = 0; tbl.push_back(r);
      r = nop(); r.lr = 1; r.ldat = 16'hDEAD; r.mv = 1; r.mrd = 1; r.mlo = 16'h0101;
      r.mhi = 16'h0202; tbl.push_back(r);
      r = nop(); tbl.push_back(wr(r, 1, 16'h0101));
      r = nop(); tbl.push_back(wr(r, 13, 16'h0202));
      r = nop(); tbl.push_back(r);

      foreach (tbl[i]) step(tbl[i], $sformatf("row%0d", i));

      // Mid-operation reset with three queued writes and one load outstanding.
      r = nop(); r.li = 1; r.lrd = 11; step(r, "rs0");
      r = nop(); r.li = 1; r.lrd = 12; r.e_busy = 16'h0800; step(r, "rs1");
      r = nop(); r.lr = 1; r.ldat = 16'hB0B0; r.mv = 1; r.mrd = 4; r.mlo = 16'h0404;
      r.mhi = 16'h1313; r.e_busy = 16'h1800; r.e_full = 1; step(r, "rs2");
      r = nop(); r.lr = 1; r.ldat = 16'hC0C0; r.av = 1; r.ard = 5; r.adat = 16'h0505;
      r.li = 1; r.lrd = 14; r.e_busy = 16'h1000; step(wr(r, 11, 16'hB0B0), "rs3");
      r = nop(); r.rsa = 4; r.e_haz = 1; r.e_stall = 1; r.e_busy = 16'h4000;
      r = wr(r, 12, 16'hC0C0);
      apply(r);
      @(negedge clk);
      check_row(r, "rs4");
      #2 rst = 1'b0;
      #1;
      chk("async wr_en", 16'(bus.wr_en), 16'h0);
      chk("async busy", bus.busy, 16'h0);
      chk("async stall", 16'(bus.stall), 16'h0);
      chk("async ld_full", 16'(bus.ld_full), 16'h0);
      chk("async hazard", 16'(bus.hazard), 16'h0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 5; i++) begin
         r = nop(); r.rsa = 4; r.rsb = 13; r.rdc = 14;
         step(r, $sformatf("post%0d", i));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
